// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: forwarding selects,
// the in-flight stage tag and the default datapath geometry.
package pipe_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RAW_DEF  = 5;
    // Tag register fields are sized for the widest supported register address.
    localparam int RAW_MAX  = 8;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic               valid;
        logic               regwrite;
        logic               memread;
        logic [RAW_MAX-1:0] dst;
        logic [RAW_MAX-1:0] rs;
        logic [RAW_MAX-1:0] rt;
        logic               use_rs;
        logic               use_rt;
    } stage_tag_t;

    localparam stage_tag_t TAG_INVALID = '0;

    // True when the tag will write register r; register 0 is excluded when hardwired.
    function automatic logic tag_writes(input stage_tag_t t,
                                        input logic [RAW_MAX-1:0] r,
                                        input logic r0_zero);
        logic hit_s;
        hit_s = t.valid & t.regwrite & (t.dst == r);
        if (r0_zero && (r == {RAW_MAX{1'b0}})) begin
            hit_s = 1'b0;
        end else begin
            hit_s = hit_s;
        end
        return hit_s;
    endfunction

endpackage

// File: rtl/pipe_tag_reg.sv
// One stage tag register. Flush or an invalid input loads the all-zero tag so an
// invalid entry can never carry regwrite.
module pipe_tag_reg
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  stage_tag_t d,
    output stage_tag_t q
);

    // Tag storage with synchronous reset and squash
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= TAG_INVALID;
        end else if (flush || !d.valid) begin
            q <= TAG_INVALID;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Load-use stall, branch flush and EX operand forwarding for a 5-stage pipeline.
// Build option HAZARD_FWD_EN: defined = full bypass; undefined = interlock-only.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RAW     = RAW_DEF,
    parameter int R0_ZERO = 1,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RAW-1:0]  id_rs,
    input  logic [RAW-1:0]  id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic [RAW-1:0]  id_dst,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            br_taken,
    input  logic [XLEN-1:0] ex_rd1,
    input  logic [XLEN-1:0] ex_rd2,
    input  logic [XLEN-1:0] mem_alu_res,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            flush_exmem,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic [XLEN-1:0] ex_opa,
    output logic [XLEN-1:0] ex_opb,
    output logic [CNTW-1:0] stall_cnt
);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    stage_tag_t         id_tag_s;
    stage_tag_t         t_ex_r;
    stage_tag_t         t_mem_r;
    stage_tag_t         t_wb_r;
    logic [RAW_MAX-1:0] id_rs_s;
    logic [RAW_MAX-1:0] id_rt_s;
    logic               r0z_s;
    logic               dep_ex_s;
    logic               hazard_s;
    logic               stall_s;
    logic               ex_flush_s;
    fwd_sel_t           fwd_a_s;
    fwd_sel_t           fwd_b_s;
    logic [XLEN-1:0]    ex_opa_s;
    logic [XLEN-1:0]    ex_opb_s;
    logic [CNTW-1:0]    cnt_r;
    logic               unused_s;

    assign r0z_s   = (R0_ZERO != 0);
    assign id_rs_s = RAW_MAX'(id_rs);
    assign id_rt_s = RAW_MAX'(id_rt);

    // Pack the ID-stage instruction into a tag for the ID/EX slot
    always_comb begin
        id_tag_s          = TAG_INVALID;
        id_tag_s.valid    = id_valid;
        id_tag_s.regwrite = id_regwrite;
        id_tag_s.memread  = id_memread;
        id_tag_s.dst      = RAW_MAX'(id_dst);
        id_tag_s.rs       = id_rs_s;
        id_tag_s.rt       = id_rt_s;
        id_tag_s.use_rs   = id_use_rs;
        id_tag_s.use_rt   = id_use_rt;
    end

    // A stall bubbles ID/EX; a taken branch squashes both younger slots.
    assign ex_flush_s = br_taken | stall_s | ~id_valid;

    pipe_tag_reg u_tag_ex (
        .clk   (clk),
        .rst   (rst),
        .flush (ex_flush_s),
        .d     (id_tag_s),
        .q     (t_ex_r)
    );

    pipe_tag_reg u_tag_mem (
        .clk   (clk),
        .rst   (rst),
        .flush (br_taken),
        .d     (t_ex_r),
        .q     (t_mem_r)
    );

    pipe_tag_reg u_tag_wb (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .d     (t_mem_r),
        .q     (t_wb_r)
    );

    assign dep_ex_s = (id_use_rs & tag_writes(t_ex_r, id_rs_s, r0z_s)) |
                      (id_use_rt & tag_writes(t_ex_r, id_rt_s, r0z_s));

`ifdef HAZARD_FWD_EN
    // Forwarding covers everything except a load still in EX.
    assign hazard_s = t_ex_r.memread & dep_ex_s;

    // EX/MEM beats MEM/WB; a load in EX/MEM has no data yet and never forwards.
    function automatic fwd_sel_t pick_src(input logic use_src,
                                          input logic [RAW_MAX-1:0] src,
                                          input stage_tag_t t_mem,
                                          input stage_tag_t t_wb,
                                          input logic r0z);
        fwd_sel_t sel_s;
        if (use_src && tag_writes(t_mem, src, r0z) && !t_mem.memread) begin
            sel_s = FWD_MEM;
        end else if (use_src && tag_writes(t_wb, src, r0z)) begin
            sel_s = FWD_WB;
        end else begin
            sel_s = FWD_REG;
        end
        return sel_s;
    endfunction

    // Operand select and bypass muxes for the EX stage
    always_comb begin
        fwd_a_s = pick_src(t_ex_r.use_rs, t_ex_r.rs, t_mem_r, t_wb_r, r0z_s);
        fwd_b_s = pick_src(t_ex_r.use_rt, t_ex_r.rt, t_mem_r, t_wb_r, r0z_s);
        case (fwd_a_s)
            FWD_MEM: ex_opa_s = mem_alu_res;
            FWD_WB:  ex_opa_s = wb_data;
            default: ex_opa_s = ex_rd1;
        endcase
        case (fwd_b_s)
            FWD_MEM: ex_opb_s = mem_alu_res;
            FWD_WB:  ex_opb_s = wb_data;
            default: ex_opb_s = ex_rd2;
        endcase
    end

    assign unused_s = ^{t_wb_r.memread, t_wb_r.rs, t_wb_r.rt, t_wb_r.use_rs, t_wb_r.use_rt};
`else
    logic dep_mem_s;

    // Without bypass, any producer still in EX or MEM holds the consumer in ID.
    assign dep_mem_s = (id_use_rs & tag_writes(t_mem_r, id_rs_s, r0z_s)) |
                       (id_use_rt & tag_writes(t_mem_r, id_rt_s, r0z_s));
    assign hazard_s  = dep_ex_s | dep_mem_s;

    // Operands always come straight from ID/EX
    always_comb begin
        fwd_a_s  = FWD_REG;
        fwd_b_s  = FWD_REG;
        ex_opa_s = ex_rd1;
        ex_opb_s = ex_rd2;
    end

    assign unused_s = ^{t_wb_r, mem_alu_res, wb_data};
`endif

    // Branch flush wins over stall: the stalled instruction is squashed anyway.
    always_comb begin
        if (id_valid && !br_taken) begin
            stall_s = hazard_s;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNTW{1'b0}};
        end else if (stall_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign stall       = stall_s;
    assign flush_ifid  = br_taken;
    assign flush_idex  = br_taken;
    assign flush_exmem = br_taken;
    assign fwd_a       = fwd_a_s;
    assign fwd_b       = fwd_b_s;
    assign ex_opa      = ex_opa_s;
    assign ex_opb      = ex_opb_s;
    assign stall_cnt   = cnt_r;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: instruction-level pipeline model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_hazard_unit;

    localparam int XLEN    = 32;
    localparam int RAW     = 5;
    localparam int CNTW    = 16;
    localparam int CNT_MAX = 65535;

    logic            clk;
    logic            rst;
    logic            id_valid;
    logic [RAW-1:0]  id_rs;
    logic [RAW-1:0]  id_rt;
    logic            id_use_rs;
    logic            id_use_rt;
    logic [RAW-1:0]  id_dst;
    logic            id_regwrite;
    logic            id_memread;
    logic            br_taken;
    logic [XLEN-1:0] ex_rd1;
    logic [XLEN-1:0] ex_rd2;
    logic [XLEN-1:0] mem_alu_res;
    logic [XLEN-1:0] wb_data;
    logic            stall;
    logic            flush_ifid;
    logic            flush_idex;
    logic            flush_exmem;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic [XLEN-1:0] ex_opa;
    logic [XLEN-1:0] ex_opb;
    logic [CNTW-1:0] stall_cnt;

    pipe_hazard_unit #(.XLEN(XLEN), .RAW(RAW), .R0_ZERO(1), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .br_taken(br_taken),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .mem_alu_res(mem_alu_res), .wb_data(wb_data),
        .stall(stall), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .flush_exmem(flush_exmem), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .ex_opa(ex_opa), .ex_opb(ex_opb), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    typedef struct {
        bit v;
        int dst;
        bit rw;
        bit mr;
        int rs;
        int rt;
        bit urs;
        bit urt;
    } ins_t;

    ins_t m_ex, m_mem, m_wb;
    int   m_cnt;

    function automatic ins_t bubble();
        ins_t b;
        b = '{v: 1'b0, dst: 0, rw: 1'b0, mr: 1'b0, rs: 0, rt: 0, urs: 1'b0, urt: 1'b0};
        return b;
    endfunction

    function automatic bit writes(input ins_t x, input int r);
        return x.v && x.rw && (x.dst == r) && (r != 0);
    endfunction

    function automatic bit exp_stall();
        bit dep_ex, dep_mem;
        dep_ex  = (id_use_rs && writes(m_ex, int'(id_rs))) || (id_use_rt && writes(m_ex, int'(id_rt)));
        dep_mem = (id_use_rs && writes(m_mem, int'(id_rs))) || (id_use_rt && writes(m_mem, int'(id_rt)));
`ifdef HAZARD_FWD_EN
        return id_valid && !br_taken && m_ex.v && m_ex.mr && dep_ex;
`else
        return id_valid && !br_taken && (dep_ex || dep_mem);
`endif
    endfunction

    function automatic int exp_sel(input int src, input bit use_src);
`ifdef HAZARD_FWD_EN
        if (use_src && writes(m_mem, src) && !m_mem.mr) return 1;
        if (use_src && writes(m_wb, src)) return 2;
`endif
        return 0;
    endfunction

    function automatic logic [XLEN-1:0] exp_op(input int sel, input logic [XLEN-1:0] rd);
        if (sel == 1) return mem_alu_res;
        if (sel == 2) return wb_data;
        return rd;
    endfunction

    // advance the model at each rising edge
    always @(posedge clk) begin
        if (rst) begin
            m_ex  <= bubble();
            m_mem <= bubble();
            m_wb  <= bubble();
            m_cnt <= 0;
        end else begin
            m_wb  <= m_mem;
            m_mem <= br_taken ? bubble() : m_ex;
            if (br_taken || exp_stall() || !id_valid)
                m_ex <= bubble();
            else
                m_ex <= '{v: 1'b1, dst: int'(id_dst), rw: id_regwrite, mr: id_memread,
                          rs: int'(id_rs), rt: int'(id_rt), urs: id_use_rs, urt: id_use_rt};
            if (exp_stall() && (m_cnt < CNT_MAX))
                m_cnt <= m_cnt + 1;
        end
    end

    // compare every cycle at the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", stall, exp_stall());
            chk("flush_ifid", flush_ifid, br_taken);
            chk("flush_idex", flush_idex, br_taken);
            chk("flush_exmem", flush_exmem, br_taken);
            chk("fwd_a", fwd_a, exp_sel(m_ex.rs, m_ex.urs));
            chk("fwd_b", fwd_b, exp_sel(m_ex.rt, m_ex.urt));
            chk("ex_opa", ex_opa, exp_op(exp_sel(m_ex.rs, m_ex.urs), ex_rd1));
            chk("ex_opb", ex_opb, exp_op(exp_sel(m_ex.rt, m_ex.urt), ex_rd2));
            chk("stall_cnt", stall_cnt, m_cnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    task automatic ins(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input int dst, input bit rw, input bit mr);
        id_valid    = v;
        id_rs       = RAW'(rs);
        id_rt       = RAW'(rt);
        id_use_rs   = urs;
        id_use_rt   = urt;
        id_dst      = RAW'(dst);
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic idle(input int n);
        ins(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        br_taken = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst = 1'b1;
        ex_rd1 = 32'hCAFE0001;
        ex_rd2 = 32'hBEEF0002;
        mem_alu_res = 32'h0;
        wb_data = 32'h0;
        idle(0);
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // reset state
        probe();
        chk("rst_stall", stall, 1'b0);
        chk("rst_flush", flush_idex, 1'b0);
        chk("rst_fwd_a", fwd_a, 2'b00);
        chk("rst_fwd_b", fwd_b, 2'b00);
        chk("rst_opa", ex_opa, 32'hCAFE0001);
        chk("rst_opb", ex_opb, 32'hBEEF0002);
        chk("rst_cnt", stall_cnt, 16'd0);
        tick();

`ifdef HAZARD_FWD_EN
        // load-use: one stall, then bypass from MEM/WB
        ins(1'b1, 1, 2, 1'b1, 1'b0, 5, 1'b1, 1'b1); tick();
        ins(1'b1, 5, 2, 1'b1, 1'b1, 6, 1'b1, 1'b0);
        probe(); chk("lu_stall", stall, 1'b1); chk("lu_cnt0", stall_cnt, 16'd0); tick();
        probe(); chk("lu_stall_end", stall, 1'b0); chk("lu_cnt1", stall_cnt, 16'd1); tick();
        idle(0); wb_data = 32'h55;
        probe(); chk("lu_fwd_a", fwd_a, 2'b10); chk("lu_opa", ex_opa, 32'h55); tick();
        idle(3);

        // back-to-back ALU dependency
        ins(1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0); tick();
        ins(1'b1, 3, 1, 1'b1, 1'b1, 4, 1'b1, 1'b0);
        probe(); chk("b2b_stall", stall, 1'b0); tick();
        idle(0); mem_alu_res = 32'h11; wb_data = 32'h99;
        probe();
        chk("b2b_fwd_a", fwd_a, 2'b01); chk("b2b_opa", ex_opa, 32'h11);
        chk("b2b_fwd_b", fwd_b, 2'b00); chk("b2b_opb", ex_opb, 32'hBEEF0002);
        tick();
        idle(3);

        // both forwarding sources match: EX/MEM wins
        ins(1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0); tick();
        tick();
        ins(1'b1, 3, 3, 1'b1, 1'b1, 7, 1'b1, 1'b0); tick();
        idle(0); mem_alu_res = 32'h22; wb_data = 32'h33;
        probe(); chk("d2_fwd_a", fwd_a, 2'b01); chk("d2_opa", ex_opa, 32'h22); chk("d2_fwd_b", fwd_b, 2'b01);
        tick();
        idle(3);

        // only MEM/WB matches
        ins(1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0); tick();
        idle(1);
        ins(1'b1, 3, 3, 1'b1, 1'b1, 7, 1'b1, 1'b0); tick();
        idle(0);
        probe(); chk("wb_fwd_a", fwd_a, 2'b10); chk("wb_opa", ex_opa, 32'h33); chk("wb_opb", ex_opb, 32'h33);
        tick();
        idle(3);
`else
        // interlock-only: dependent ALU op stalls two cycles, never forwards
        ins(1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0); tick();
        ins(1'b1, 3, 1, 1'b1, 1'b1, 4, 1'b1, 1'b0);
        probe(); chk("il_stall1", stall, 1'b1); chk("il_fwd1", fwd_a, 2'b00); tick();
        probe(); chk("il_stall2", stall, 1'b1); chk("il_fwd2", fwd_a, 2'b00); tick();
        probe(); chk("il_stall_end", stall, 1'b0); chk("il_cnt", stall_cnt, 16'd2); tick();
        idle(0); mem_alu_res = 32'h11; wb_data = 32'h99;
        probe(); chk("il_fwd_a", fwd_a, 2'b00); chk("il_opa", ex_opa, 32'hCAFE0001); tick();
        idle(3);
`endif

        // taken branch while a load-use hazard is present
        ins(1'b1, 1, 2, 1'b1, 1'b0, 6, 1'b1, 1'b1); tick();
        ins(1'b1, 6, 6, 1'b1, 1'b1, 8, 1'b1, 1'b0); br_taken = 1'b1;
        probe();
        chk("br_stall", stall, 1'b0);
        chk("br_flush_ifid", flush_ifid, 1'b1);
        chk("br_flush_idex", flush_idex, 1'b1);
        chk("br_flush_exmem", flush_exmem, 1'b1);
        tick();
        br_taken = 1'b0;
        probe(); chk("br_post_stall", stall, 1'b0); tick();
        idle(0);
        probe(); chk("br_post_fwd_a", fwd_a, 2'b00); chk("br_post_fwd_b", fwd_b, 2'b00); tick();
        idle(3);

        // register 0 never matches
        ins(1'b1, 1, 2, 1'b1, 1'b1, 0, 1'b1, 1'b0); tick();
        ins(1'b1, 1, 2, 1'b1, 1'b1, 0, 1'b1, 1'b1); tick();
        ins(1'b1, 0, 0, 1'b1, 1'b1, 9, 1'b1, 1'b0);
        probe(); chk("r0_stall", stall, 1'b0); tick();
        idle(0);
        probe(); chk("r0_fwd_a", fwd_a, 2'b00); chk("r0_fwd_b", fwd_b, 2'b00); tick();
        idle(3);

        // reset asserted during a stall
        ins(1'b1, 1, 2, 1'b1, 1'b0, 7, 1'b1, 1'b1); tick();
        ins(1'b1, 7, 1, 1'b1, 1'b1, 9, 1'b1, 1'b0); rst = 1'b1;
        probe(); chk("rs_stall", stall, 1'b1); tick();
        rst = 1'b0;
        probe(); chk("rs_stall_after", stall, 1'b0); chk("rs_cnt", stall_cnt, 16'd0); tick();
        idle(2);

        // randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 249) == 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            id_rs       = RAW'($urandom_range(0, 3));
            id_rt       = RAW'($urandom_range(0, 3));
            id_dst      = RAW'($urandom_range(0, 3));
            id_use_rs   = ($urandom_range(0, 3) != 0);
            id_use_rt   = ($urandom_range(0, 2) != 0);
            id_regwrite = ($urandom_range(0, 3) != 0);
            id_memread  = ($urandom_range(0, 2) == 0);
            br_taken    = ($urandom_range(0, 7) == 0);
            ex_rd1      = $urandom();
            ex_rd2      = $urandom();
            mem_alu_res = $urandom();
            wb_data     = $urandom();
            tick();
        end
        rst = 1'b0;
        idle(2);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
